// File: rtl/imem_pkg.sv
// Shared sizes and FSM state type for the instruction-memory loader.
package imem_pkg;
  localparam int IMEM_N     = 32;
  localparam int IMEM_DEPTH = 128;
  localparam int AW         = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DONE
  } state_e;
endpackage

// File: rtl/iram.sv
// DEPTH x N word store: one synchronous write port, one combinational read port.
// A same-address read during a write returns the old word.
module iram
  import imem_pkg::*;
#(
  parameter int N     = IMEM_N,
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [N-1:0]  rdata_o
);

  logic [N-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Loads a little-endian byte stream into instruction RAM after clearing it; the CPU is held in reset until done.
// in_ready is high only while loading; q is a zero-latency read of the RAM.
module imem_loader
  import imem_pkg::*;
#(
  parameter int N     = IMEM_N,
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    word_count,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic [AW-1:0] addr,
  output logic [N-1:0]  q,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int              LANES     = N / 8;
  localparam int              BCW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [7:0]      MAX_COUNT = 8'(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [BCW-1:0]  LAST_LANE = BCW'(LANES - 1);

  state_e         state_q, state_d;
  logic [7:0]     count_q, count_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  clr_ptr_q, clr_ptr_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [N-1:0]   word_q, word_d;
  logic           err_q, err_d;

  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [N-1:0]   mem_wdata;
  logic [N-1:0]   merged;
  logic           count_ok;
  logic           last_word;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    clr_ptr_d  = clr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = clr_ptr_q;
    mem_wdata  = '0;

    count_ok  = (word_count != 8'd0) && (word_count <= MAX_COUNT);
    last_word = ({1'b0, wr_ptr_q} == (count_q - 8'd1));

    // Current partial word with the incoming byte dropped into its lane.
    merged = word_q;
    for (int i = 0; i < LANES; i++) begin
      if (byte_cnt_q == BCW'(i)) begin
        merged[i*8 +: 8] = in_data;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (count_ok) begin
            count_d    = word_count;
            wr_ptr_d   = '0;
            clr_ptr_d  = '0;
            byte_cnt_d = '0;
            word_d     = '0;
            state_d    = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = S_LOAD;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (byte_cnt_q == LAST_LANE) begin
            mem_we     = 1'b1;
            mem_waddr  = wr_ptr_q;
            mem_wdata  = merged;
            word_d     = '0;
            byte_cnt_d = '0;
            // wr_ptr holds on the final word so it never runs past the count.
            if (last_word) begin
              state_d = S_DONE;
            end else begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end else begin
            word_d     = merged;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      clr_ptr_q  <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      clr_ptr_q  <= clr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q == S_CLEAR) || (state_q == S_LOAD);
  assign done     = (state_q == S_DONE);
  assign cpu_hold = (state_q != S_DONE);
  assign err      = err_q;

  iram #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_iram (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (addr),
    .rdata_o (q)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: driver queues expectations, a negedge monitor pops and compares.
module tb_imem_loader;

  localparam int K_Q = 0, K_STATUS = 1, K_ERRCNT = 2, K_ACC = 3;
  // status = {cpu_hold, busy, done, in_ready}
  localparam logic [31:0] ST_IDLE  = 32'h8;
  localparam logic [31:0] ST_CLEAR = 32'hC;
  localparam logic [31:0] ST_LOAD  = 32'hD;
  localparam logic [31:0] ST_DONE  = 32'h2;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    int          tag;
  } chk_t;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  word_count, in_data;
  logic [6:0]  addr;
  logic        in_ready, cpu_hold, busy, done, err;
  logic [31:0] q;
  logic        chk_vld;

  chk_t        sb_q[$];
  logic [7:0]  stim[$];
  logic [31:0] mem_m [128];
  int          vectors = 0, miscompares = 0;
  int          err_cnt = 0, acc_cnt = 0, acc_exp = 0;
  logic [31:0] old0;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .addr       (addr),
    .q          (q),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    chk_t        e;
    logic [31:0] act;
    string       nm;
    if (in_valid && in_ready) acc_cnt++;
    if (err) err_cnt++;
    if (chk_vld) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        case (e.kind)
          K_Q:      begin act = q;                                      nm = "q_word";  end
          K_STATUS: begin act = {28'd0, cpu_hold, busy, done, in_ready}; nm = "status";  end
          K_ERRCNT: begin act = 32'(err_cnt);                           nm = "err_cnt"; end
          default:  begin act = 32'(acc_cnt);                           nm = "acc_cnt"; end
        endcase
        if (act !== e.exp) begin
          miscompares++;
          $display("FAIL %s tag=%0d got=%h exp=%h t=%0t", nm, e.tag, act, e.exp, $time);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input logic [31:0] exp, input int tag);
    chk_t e;
    e.kind = kind; e.exp = exp; e.tag = tag;
    sb_q.push_back(e);
    chk_vld = 1'b1;
    tick();
    chk_vld = 1'b0;
  endtask

  task automatic do_start(input int cnt);
    word_count = 8'(cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic model_clear();
    for (int a = 0; a < 128; a++) mem_m[a] = 32'd0;
  endtask

  // Expected RAM after a load: word k is bytes 4k..4k+3, little-endian.
  task automatic model_apply(input int nbytes);
    for (int k = 0; k < nbytes / 4; k++)
      mem_m[k] = {stim[4*k+3], stim[4*k+2], stim[4*k+1], stim[4*k]};
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  task automatic send_n(input int n, input int gap_pct);
    logic [7:0] b;
    logic       fire;
    int         waited;
    for (int i = 0; i < n; i++) begin
      b = stim.pop_front();
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = b;
      waited   = 0;
      do begin
        fire = in_ready;
        tick();
        waited++;
      end while (!fire && waited < 400);
      if (fire) begin
        acc_exp++;
      end else begin
        vectors++;
        miscompares++;
        $display("FAIL byte_accept_timeout byte=%0d got=0 exp=1", i);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_all(input int base_tag);
    for (int a = 0; a < 128; a++) begin
      addr = 7'(a);
      chk(K_Q, mem_m[a], base_tag + a);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    word_count = 8'd0; in_data = 8'd0; addr = 7'd0; chk_vld = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk(K_STATUS, ST_IDLE, 1);
    chk(K_ERRCNT, 32'd0, 2);
    chk(K_ACC, 32'd0, 3);

    // Rejected counts.
    do_start(0); tick(); tick();
    chk(K_ERRCNT, 32'd1, 10);
    chk(K_STATUS, ST_IDLE, 11);
    do_start(129); tick(); tick();
    chk(K_ERRCNT, 32'd2, 12);
    chk(K_STATUS, ST_IDLE, 13);

    // Fixed two-word program.
    model_clear();
    stim = '{8'h01, 8'h00, 8'h00, 8'hf8, 8'h02, 8'h80, 8'h00, 8'hf8};
    model_apply(8);
    do_start(2);
    send_n(8, 0);
    tick();
    chk(K_STATUS, ST_DONE, 20);
    check_all(1000);

    // Preload, then a one-word load must clear everything first.
    model_clear();
    fill_rand(16);
    model_apply(16);
    do_start(4);
    send_n(16, 20);
    tick();
    chk(K_STATUS, ST_DONE, 30);
    check_all(2000);
    do_start(1);
    for (int i = 0; i < 128; i++) begin
      in_valid = (i < 127);
      in_data  = 8'hA5;
      chk(K_STATUS, ST_CLEAR, 3000 + i);
    end
    in_valid = 1'b0;
    chk(K_STATUS, ST_LOAD, 31);
    chk(K_ACC, 32'(acc_exp), 32);
    model_clear();
    old0 = mem_m[0];
    fill_rand(4);
    model_apply(4);
    send_n(3, 0);
    // Fourth byte: the write to word 0 lands on this edge, q still shows the old word.
    in_valid = 1'b1;
    in_data  = stim.pop_front();
    addr     = 7'd0;
    chk(K_Q, old0, 33);
    in_valid = 1'b0;
    acc_exp++;
    chk(K_STATUS, ST_DONE, 34);
    check_all(4000);

    // Full-depth random load with gaps; the 513th byte is refused.
    model_clear();
    fill_rand(512);
    model_apply(512);
    do_start(128);
    send_n(512, 30);
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    for (int i = 0; i < 5; i++) chk(K_STATUS, ST_DONE, 40 + i);
    in_valid = 1'b0;
    chk(K_ACC, 32'(acc_exp), 45);
    check_all(5000);

    // Reset mid-load keeps word 0, partial word 1 is never written.
    model_clear();
    fill_rand(12);
    model_apply(4);
    do_start(3);
    send_n(6, 10);
    stim.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk(K_STATUS, ST_IDLE, 50);
    check_all(6000);
    model_clear();
    fill_rand(12);
    model_apply(12);
    do_start(3);
    send_n(12, 10);
    tick();
    chk(K_STATUS, ST_DONE, 51);
    check_all(7000);

    // start during LOAD is ignored; start from DONE begins a fresh load.
    model_clear();
    fill_rand(8);
    model_apply(8);
    do_start(2);
    send_n(3, 0);
    do_start(0);
    do_start(1);
    chk(K_STATUS, ST_LOAD, 60);
    send_n(5, 0);
    tick();
    chk(K_STATUS, ST_DONE, 61);
    chk(K_ERRCNT, 32'd2, 62);
    check_all(8000);
    do_start(1);
    chk(K_STATUS, ST_CLEAR, 63);
    model_clear();
    fill_rand(4);
    model_apply(4);
    send_n(4, 15);
    tick();
    chk(K_STATUS, ST_DONE, 64);
    chk(K_ACC, 32'(acc_exp), 65);
    check_all(9000);

    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
